// File: rtl/package_settings.sv
// Project-wide settings shared by the ADC front-end blocks.
//   SIZE_ADC_DATA : width of an ADC sample word.
package package_settings;
  localparam int SIZE_ADC_DATA = 12;
endpackage

// File: rtl/adc_pulse_gen.sv
// adc_pulse_gen
// Synthetic ADC stimulus source. It produces a train of exponentially
// decaying pulses sitting on a pedestal, one registered sample per clock.
// The output is sized to feed the shaping filter input directly.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   reset       asynchronous, active-high reset
//   start       begin a pulse train (only looked at while idle)
//   amplitude   unsigned step height above baseline
//   baseline    unsigned pedestal level
//   num_pulses  number of pulses in the train (0 = immediate done)
//   gap_len     baseline cycles inserted after each pulse tail
//   adc_data    registered synthetic sample
//   pulse_mark  high for the single cycle carrying a pulse peak
//   busy        high while a train is running, through the done cycle
//   done        single-cycle completion strobe
module adc_pulse_gen #(
  parameter int SIZE_ADC_DATA = package_settings::SIZE_ADC_DATA,
  parameter int DECAY_SHIFT   = 4,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  input  logic [SIZE_ADC_DATA-1:0] baseline,
  input  logic [7:0]               num_pulses,
  input  logic [CNT_W-1:0]         gap_len,
  output logic [SIZE_ADC_DATA-1:0] adc_data,
  output logic                     pulse_mark,
  output logic                     busy,
  output logic                     done
);

  localparam int W = SIZE_ADC_DATA;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_DECAY = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]       r_state;
  logic [W-1:0]     r_amp;
  logic [W-1:0]     r_base;
  logic [W-1:0]     r_tail;
  logic [7:0]       r_remaining;
  logic [CNT_W-1:0] r_gap_len;
  logic [CNT_W-1:0] r_cnt;
  logic             r_zero_pend;   // num_pulses=0 accepted, done due next edge
  logic [W-1:0]     r_adc;
  logic             r_mark;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic [W-1:0]     w_tail_shift;
  logic [W-1:0]     w_tail_dec;
  logic [W-1:0]     w_peak;
  logic [W-1:0]     w_dec_sample;
  logic             w_tail_dead;
  logic             w_pulse_end;
  logic             w_last;

  // Baseline plus offset, summed one bit wider and clamped to full scale.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[W] ? {W{1'b1}} : sum[W-1:0];
  endfunction

  // While r_busy is still high in IDLE we are in the done cycle, so a new
  // start is not taken until busy has dropped.
  assign w_accept     = (r_state == S_IDLE) && start && !r_busy && !r_zero_pend;

  // tail - (tail >> k) can never underflow because the shifted value is
  // never larger than tail itself.
  assign w_tail_shift = r_tail >> DECAY_SHIFT;
  assign w_tail_dec   = r_tail - w_tail_shift;
  assign w_tail_dead  = (w_tail_shift == '0);
  assign w_peak       = sat_add(r_base, r_amp);
  assign w_dec_sample = sat_add(r_base, w_tail_dec);
  assign w_last       = (r_remaining <= 8'd1);

  // A pulse ends either straight out of DECAY when no gap is requested, or
  // on the last GAP cycle. The counter holds the GAP cycles still to run.
  assign w_pulse_end  = ((r_state == S_DECAY) && w_tail_dead && (r_gap_len == '0)) ||
                        ((r_state == S_GAP) && (r_cnt <= CNT_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_amp       <= '0;
      r_base      <= '0;
      r_tail      <= '0;
      r_remaining <= '0;
      r_gap_len   <= '0;
      r_cnt       <= '0;
      r_zero_pend <= 1'b0;
      r_adc       <= '0;
      r_mark      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mark <= 1'b0;
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_adc <= r_base;
          if (r_busy) begin
            r_busy <= 1'b0;
          end
          if (r_zero_pend) begin
            r_zero_pend <= 1'b0;
            r_done      <= 1'b1;
          end
          if (w_accept) begin
            r_amp       <= amplitude;
            r_base      <= baseline;
            r_gap_len   <= gap_len;
            r_remaining <= num_pulses;
            r_adc       <= baseline;
            if (num_pulses == 8'd0) begin
              r_zero_pend <= 1'b1;
            end else begin
              r_state <= S_STEP;
              r_busy  <= 1'b1;
            end
          end
        end

        S_STEP: begin
          r_tail  <= r_amp;
          r_adc   <= w_peak;
          r_mark  <= 1'b1;
          r_state <= S_DECAY;
        end

        S_DECAY: begin
          if (w_tail_dead) begin
            r_tail  <= '0;
            r_adc   <= r_base;
            r_cnt   <= r_gap_len;
            r_state <= S_GAP;
          end else begin
            r_tail <= w_tail_dec;
            r_adc  <= w_dec_sample;
          end
        end

        S_GAP: begin
          r_adc <= r_base;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // End-of-pulse routing overrides the per-state next state above.
      if (w_pulse_end) begin
        if (!w_last) begin
          r_remaining <= r_remaining - 8'd1;
          r_state     <= S_STEP;
        end else begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign adc_data   = r_adc;
  assign pulse_mark = r_mark;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_adc_pulse_gen.sv
module tb_adc_pulse_gen;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] amplitude;
  logic [W-1:0] baseline;
  logic [7:0]   num_pulses;
  logic [15:0]  gap_len;
  logic [W-1:0] adc_data;
  logic         pulse_mark;
  logic         busy;
  logic         done;

  adc_pulse_gen #(.SIZE_ADC_DATA(W), .DECAY_SHIFT(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .amplitude  (amplitude),
    .baseline   (baseline),
    .num_pulses (num_pulses),
    .gap_len    (gap_len),
    .adc_data   (adc_data),
    .pulse_mark (pulse_mark),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int amp;
    int base;
    int num;
    int gap;
    int exp_peak;
    int exp_second;
    int exp_marks;
  } vec_t;

  vec_t vecs[6];

  int n_total = 0;
  int n_pass  = 0;

  // Expected per-cycle stream, one entry per sample taken after each edge.
  int e_adc[$];
  int e_mark[$];
  int e_busy[$];
  int e_done[$];

  // Observations from the last train.
  int obs_marks;
  int obs_dones;
  int obs_peak;
  int obs_second;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sat12(input int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  task automatic push(input int a, input int m, input int b, input int d);
    e_adc.push_back(a);
    e_mark.push_back(m);
    e_busy.push_back(b);
    e_done.push_back(d);
  endtask

  // Behavioural reference: accept sample, then per pulse the peak, the
  // decay samples ending in one baseline sample, then gap baseline samples.
  // The final sample of the last pulse carries done; then one idle sample.
  task automatic build_model(input int amp, input int base, input int num, input int gap);
    int tail;
    int d;
    e_adc.delete(); e_mark.delete(); e_busy.delete(); e_done.delete();
    push(base, 0, 1, 0);
    for (int p = 0; p < num; p++) begin
      push(sat12(base + amp), 1, 1, 0);
      tail = amp;
      while (1) begin
        d = tail / 16;
        if (d == 0) begin
          push(base, 0, 1, 0);
          break;
        end
        tail = tail - d;
        push(sat12(base + tail), 0, 1, 0);
      end
      for (int g = 0; g < gap; g++) push(base, 0, 1, 0);
      if (p == num - 1) e_done[e_done.size() - 1] = 1;
    end
    push(base, 0, 0, 0);
  endtask

  // Runs one train and compares every sample to the model. When retrig_at
  // is non-negative, a second start with different inputs is pulsed at
  // that sample index; it must have no effect.
  task automatic run_train(input string tag, input int amp, input int base,
                           input int num, input int gap, input int retrig_at);
    int n;
    int seen_mark;
    build_model(amp, base, num, gap);
    obs_marks = 0; obs_dones = 0; obs_peak = -1; obs_second = -1;
    seen_mark = 0;
    @(negedge clk);
    amplitude  = W'(amp);
    baseline   = W'(base);
    num_pulses = 8'(num);
    gap_len    = 16'(gap);
    start      = 1'b1;
    n = e_adc.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) start = 1'b0;
      if (retrig_at >= 0 && i == retrig_at) begin
        start = 1'b1; amplitude = 12'd77; num_pulses = 8'd9; gap_len = 16'd1;
      end
      if (retrig_at >= 0 && i == retrig_at + 2) start = 1'b0;
      n_total++;
      if (int'(adc_data) == e_adc[i] && int'(pulse_mark) == e_mark[i] &&
          int'(busy) == e_busy[i] && int'(done) == e_done[i]) begin
        n_pass++;
      end else begin
        $display("FAIL %s sample %0d: got adc=%0d mark=%0d busy=%0d done=%0d, expected adc=%0d mark=%0d busy=%0d done=%0d",
                 tag, i, adc_data, pulse_mark, busy, done, e_adc[i], e_mark[i], e_busy[i], e_done[i]);
      end
      if (done) obs_dones++;
      if (seen_mark == 1) begin
        obs_second = int'(adc_data);
        seen_mark = 2;
      end
      if (pulse_mark) begin
        obs_marks++;
        if (seen_mark == 0) begin
          obs_peak = int'(adc_data);
          seen_mark = 1;
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{amp:1024, base:100,  num:1, gap:10, exp_peak:1124, exp_second:1060, exp_marks:1};
    vecs[1] = '{amp:1000, base:4000, num:1, gap:3,  exp_peak:4095, exp_second:4095, exp_marks:1};
    vecs[2] = '{amp:500,  base:0,    num:3, gap:5,  exp_peak:500,  exp_second:469,  exp_marks:3};
    vecs[3] = '{amp:15,   base:7,    num:1, gap:2,  exp_peak:22,   exp_second:7,    exp_marks:1};
    vecs[4] = '{amp:40,   base:50,   num:2, gap:0,  exp_peak:90,   exp_second:88,   exp_marks:2};
    vecs[5] = '{amp:4095, base:4095, num:1, gap:1,  exp_peak:4095, exp_second:4095, exp_marks:1};

    reset = 1'b1; start = 1'b0; amplitude = '0; baseline = '0;
    num_pulses = '0; gap_len = '0;

    // Reset state.
    @(posedge clk); #1;
    chk("reset adc_data", int'(adc_data), 0);
    chk("reset flags", int'({pulse_mark, busy, done}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post-reset idle adc_data", int'(adc_data), 0);

    // Table-driven trains.
    for (int v = 0; v < 6; v++) begin
      run_train($sformatf("vec%0d", v), vecs[v].amp, vecs[v].base,
                vecs[v].num, vecs[v].gap, -1);
      chk($sformatf("vec%0d peak", v), obs_peak, vecs[v].exp_peak);
      chk($sformatf("vec%0d second sample", v), obs_second, vecs[v].exp_second);
      chk($sformatf("vec%0d pulse_mark count", v), obs_marks, vecs[v].exp_marks);
      chk($sformatf("vec%0d done count", v), obs_dones, 1);
    end

    // num_pulses = 0: baseline latched, done one cycle later, busy stays low.
    @(negedge clk);
    amplitude = 12'd300; baseline = 12'd321; num_pulses = 8'd0; gap_len = 16'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("num0 k adc_data", int'(adc_data), 321);
    chk("num0 k busy/done/mark", int'({busy, done, pulse_mark}), 0);
    @(posedge clk); #1;
    chk("num0 k+1 done", int'(done), 1);
    chk("num0 k+1 busy/mark", int'({busy, pulse_mark}), 0);
    @(posedge clk); #1;
    chk("num0 k+2 done", int'(done), 0);
    chk("num0 k+2 adc_data", int'(adc_data), 321);

    // Start pulsed during DECAY is ignored.
    run_train("retrig", 1024, 100, 1, 10, 3);
    chk("retrig pulse_mark count", obs_marks, 1);
    chk("retrig done count", obs_dones, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("retrig stays idle", int'({busy, pulse_mark}), 0);

    // Reset during DECAY aborts immediately, no done afterwards.
    @(negedge clk);
    amplitude = 12'd1024; baseline = 12'd100; num_pulses = 8'd2; gap_len = 16'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre-abort busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("abort adc_data", int'(adc_data), 0);
    chk("abort busy/done/mark", int'({busy, done, pulse_mark}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    begin
      int dones_seen = 0;
      int busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (done) dones_seen++;
        if (busy) busy_seen++;
      end
      chk("abort no done", dones_seen, 0);
      chk("abort no busy", busy_seen, 0);
      chk("abort idle adc_data", int'(adc_data), 0);
    end
    run_train("after-abort", 15, 7, 1, 2, -1);
    chk("after-abort peak", obs_peak, 22);
    chk("after-abort done count", obs_dones, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time bound in case the DUT never finishes its train.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
